vga_timing_rx: RTL and testbench
================================

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL be the expected active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, SHALL be the expected active lines per frame.
REQ-003 Parameter SYNC_ACT, default 1'b0, SHALL be the active level of hsync and vsync (0 = active-low).
REQ-004 Parameter LOCK_FRAMES, default 2, range 1..15, SHALL be the number of consecutive good frames required for lock.
REQ-005 clk  input  1  pixel clock; the only clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 hsync, vsync, de  input  1 each  timing signals, synchronous to clk.
REQ-008 rgb_in  input  12  pixel {r,g,b}, 4 bits each, qualified by de.
REQ-009 px_x, px_y  output  11 each  recovered active-area coordinates.
REQ-010 px_valid  output  1  px_x/px_y/px_rgb valid.
REQ-011 px_rgb  output  12  pixel aligned with px_x/px_y.
REQ-012 frame_start  output  1  one-cycle pulse at each vsync active edge.
REQ-013 line_len, frame_lines  output  11 each  last measured active line length and active line count.
REQ-014 locked  output  1  high in LOCK state.
REQ-015 err  output  1  sticky timing-error flag.

Function
REQ-016 Inputs SHALL be registered once (stage 1); edges SHALL be detected against a second register (stage 2); px_* and frame_start SHALL appear exactly 2 cycles after the input sample.
REQ-017 px_x SHALL be 0 on the first de-high cycle of a line, incrementing per de-high cycle, saturating at 2047.
REQ-018 px_y SHALL reset to 0 on a vsync active edge and increment on each de rising edge after the first of the frame, saturating at 2047.
REQ-019 If a vsync active edge and a de rising edge coincide, that line SHALL be px_y = 0.
REQ-020 line_len SHALL load the de-high count at each de falling edge; frame_lines SHALL load the active-line count at each vsync active edge.
REQ-021 A frame SHALL be good iff every line_len equals H_ACTIVE and frame_lines equals V_ACTIVE.
REQ-022 FSM states SEARCH, ACQ, LOCK; SEARCH->ACQ on first vsync active edge with good count 0.
REQ-023 In ACQ at each vsync active edge: good frame increments count, reaching LOCK_FRAMES -> LOCK; bad frame clears count, stays ACQ.
REQ-024 In LOCK: line_len != H_ACTIVE at a de falling edge, or a bad frame at vsync edge, SHALL go to SEARCH the next cycle.
REQ-025 err SHALL set on any bad line/frame while in LOCK, or de high while hsync is at SYNC_ACT; it SHALL clear only on reset.
REQ-026 Before the first vsync edge px_valid SHALL still follow de, with px_y counting from 0.

Reset
REQ-027 On rst_n low all outputs, counters, pipeline registers SHALL be 0, FSM SHALL be SEARCH, immediately and asynchronously.
REQ-028 Reset mid-line SHALL discard partial counts; after release, the first de-high cycle SHALL yield px_x = 0, px_y = 0.

Configuration
REQ-029 With VGA_TIMING_RX_CRC_EN defined, outputs frame_crc (16) and crc_valid (1) SHALL exist: CRC-16-CCITT (poly 0x1021, seed 0xFFFF) over rgb_in zero-extended to 16 bits per de cycle, presented with a one-cycle crc_valid at each vsync active edge, then reseeded.
REQ-030 Without VGA_TIMING_RX_CRC_EN those ports and logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-031 Shared package vga_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the 640x480 porch/sync constants, and the FSM state encoding.
REQ-032 The CRC SHALL be a sub-module vga_crc16 (clk, rst_n, clr, en, data, crc), instantiated only under VGA_TIMING_RX_CRC_EN.

Verification
REQ-033 Three clean 800x525 frames (640x480 active, active-low sync) -> locked high 2 cycles after the 2nd good frame's closing vsync edge (LOCK_FRAMES=2); err = 0.
REQ-034 Locked stream, line 100 given 639 de cycles -> locked low the cycle after that de falling edge, err = 1, line_len = 639.
REQ-035 Pixel (x=5, y=3) rgb_in = 12'hA5C -> px_x = 5, px_y = 3, px_rgb = 12'hA5C, px_valid = 1 exactly 2 cycles later.
REQ-036 rst_n low for 1 cycle mid-line 200 -> all outputs 0, state SEARCH; next de run reports px_x = 0, px_y = 0.
REQ-037 CRC build, frame of all rgb_in = 0 -> crc_valid pulse at vsync edge with frame_crc equal to the golden model; non-CRC build compiles without frame_crc.
REQ-038 de asserted while hsync low (active) -> err = 1 within 2 cycles, sticky until reset.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing receiver.
// Holds the default active-area size, the standard 640x480@60 porch/sync
// constants, the counter saturation limit, CRC constants and the lock-FSM
// state encoding. No ports.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // 640x480 reference timing, in pixel clocks / lines
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = 800;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = 525;

  localparam logic [10:0] CNT_MAX = 11'd2047;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCK   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_crc16.sv
// CRC-16-CCITT accumulator (poly 0x1021, seed 0xFFFF), 16 data bits per
// enabled cycle, MSB first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (register -> seed)
//   clr        : reseed; if en is also high the word is folded into the seed
//   en         : absorb data this cycle
//   data[15:0] : word to absorb
//   crc[15:0]  : current accumulator value
module vga_crc16
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_SEED;
    end else if (clr) begin
      crc <= en ? crc_step(CRC_SEED, data) : CRC_SEED;
    end else if (en) begin
      crc <= crc_step(crc, data);
    end
  end

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers active-area pixel coordinates from
// hsync/vsync/de, measures line length and active line count, and runs a
// SEARCH/ACQ/LOCK qualifier that declares lock after LOCK_FRAMES
// consecutive good frames.
// Optional build macro VGA_TIMING_RX_CRC_EN adds a per-frame CRC-16 over
// the active pixels (frame_crc / crc_valid).
// Ports:
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   hsync, vsync, de    : input timing (active level SYNC_ACT for syncs)
//   rgb_in[11:0]        : {r,g,b} pixel, qualified by de
//   px_x, px_y [10:0]   : active-area coordinates of px_rgb
//   px_valid            : px_x/px_y/px_rgb valid
//   px_rgb[11:0]        : pixel aligned with px_x/px_y
//   frame_start         : one-cycle pulse per vsync active edge
//   line_len[10:0]      : last measured de-high run length
//   frame_lines[10:0]   : last measured active-line count
//   locked              : lock FSM is in LOCK
//   err                 : sticky timing-error flag
//   frame_crc[15:0], crc_valid : (CRC build only) per-frame CRC and strobe
// All outputs appear two clocks after the input sample that caused them.
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_DEF,
  parameter int   V_ACTIVE    = V_ACTIVE_DEF,
  parameter logic SYNC_ACT    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [11:0] rgb_in,
  output logic [10:0] px_x,
  output logic [10:0] px_y,
  output logic        px_valid,
  output logic [11:0] px_rgb,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        err
`ifdef VGA_TIMING_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic [10:0] H_EXP  = 11'(H_ACTIVE);
  localparam logic [10:0] V_EXP  = 11'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  logic        hs_p1, vs_p1, vld_p1;
  logic [11:0] rgb_p1;

  logic        vs_p2, vld_p2, fs_p2;
  logic [11:0] rgb_p2;
  logic [10:0] x_p2, y_p2;

  logic [10:0] h_cnt, lines_cnt, line_len_q, frame_lines_q;
  logic        line_seen, frame_bad, err_q;
  logic [3:0]  good_cnt;
  rx_state_t   state;

  logic        vs_edge, de_rise, de_fall, bad_line, frame_good;
  logic        sync_err, lock_loss, seen_next;
  logic [10:0] y_next;

  always_comb begin
    vs_edge    = (vs_p1 == SYNC_ACT) && (vs_p2 != SYNC_ACT);
    de_rise    = vld_p1 && !vld_p2;
    de_fall    = !vld_p1 && vld_p2;
    bad_line   = de_fall && (h_cnt != H_EXP);
    // A line ending on the same cycle as the vsync edge still belongs to
    // the closing frame, hence the bad_line term.
    frame_good = !frame_bad && !bad_line && (lines_cnt == V_EXP);
    sync_err   = vld_p1 && (hs_p1 == SYNC_ACT);
    lock_loss  = (state == ST_LOCK) && (bad_line || (vs_edge && !frame_good));

    // line_seen marks that the frame's first line has started; until then
    // a de rise keeps px_y at 0 instead of incrementing. A de rise on the
    // vsync edge itself opens line 0 of the new frame.
    y_next    = y_p2;
    seen_next = line_seen;
    if (vs_edge) begin
      y_next    = 11'd0;
      seen_next = 1'b0;
    end
    if (de_rise) begin
      y_next    = (vs_edge || !line_seen) ? 11'd0 : sat_inc(y_p2);
      seen_next = 1'b1;
    end
  end

  // Stage 1: input registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      rgb_p1 <= '0;
    end else begin
      hs_p1  <= hsync;
      vs_p1  <= vsync;
      vld_p1 <= de;
      rgb_p1 <= rgb_in;
    end
  end

  // Stage 2: edge reference, coordinate counters, measurement and lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_p2         <= 1'b0;
      vld_p2        <= 1'b0;
      fs_p2         <= 1'b0;
      rgb_p2        <= '0;
      x_p2          <= '0;
      y_p2          <= '0;
      h_cnt         <= '0;
      lines_cnt     <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      line_seen     <= 1'b0;
      frame_bad     <= 1'b0;
      err_q         <= 1'b0;
      good_cnt      <= '0;
      state         <= ST_SEARCH;
    end else begin
      vs_p2     <= vs_p1;
      vld_p2    <= vld_p1;
      fs_p2     <= vs_edge;
      rgb_p2    <= rgb_p1;
      y_p2      <= y_next;
      line_seen <= seen_next;

      if (vld_p1) begin
        if (de_rise) begin
          x_p2  <= 11'd0;
          h_cnt <= 11'd1;
        end else begin
          x_p2  <= sat_inc(x_p2);
          h_cnt <= sat_inc(h_cnt);
        end
      end

      if (de_fall) begin
        line_len_q <= h_cnt;
      end

      if (vs_edge) begin
        frame_lines_q <= lines_cnt;
        lines_cnt     <= de_rise ? 11'd1 : 11'd0;
        frame_bad     <= 1'b0;
      end else begin
        if (de_rise) begin
          lines_cnt <= sat_inc(lines_cnt);
        end
        if (bad_line) begin
          frame_bad <= 1'b1;
        end
      end

      if (lock_loss || sync_err) begin
        err_q <= 1'b1;
      end

      case (state)
        ST_SEARCH: begin
          if (vs_edge) begin
            state    <= ST_ACQ;
            good_cnt <= '0;
          end
        end
        ST_ACQ: begin
          if (vs_edge) begin
            if (frame_good) begin
              good_cnt <= good_cnt + 4'd1;
              if ((good_cnt + 4'd1) == LOCK_N) begin
                state <= ST_LOCK;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end
        ST_LOCK: begin
          if (lock_loss) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          good_cnt <= '0;
        end
      endcase
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x        <= '0;
      px_y        <= '0;
      px_valid    <= 1'b0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      px_x        <= x_p2;
      px_y        <= y_p2;
      px_valid    <= vld_p2;
      px_rgb      <= rgb_p2;
      frame_start <= fs_p2;
      line_len    <= line_len_q;
      frame_lines <= frame_lines_q;
      locked      <= (state == ST_LOCK);
      err         <= err_q;
    end
  end

`ifdef VGA_TIMING_RX_CRC_EN
  logic [15:0] crc_cur, crc_p2;
  logic        crc_vld_p2;

  // The word on the vsync-edge cycle is the first of the new frame, so the
  // closing value is taken from the accumulator before that cycle's update.
  vga_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (vs_edge),
    .en    (vld_p1),
    .data  ({4'h0, rgb_p1}),
    .crc   (crc_cur)
  );

  // Stage 2: capture closing CRC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_p2     <= '0;
      crc_vld_p2 <= 1'b0;
    end else begin
      crc_vld_p2 <= vs_edge;
      if (vs_edge) begin
        crc_p2 <= crc_cur;
      end
    end
  end

  // Stage 3: registered CRC outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      frame_crc <= crc_p2;
      crc_valid <= crc_vld_p2;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a scaled-down raster:
// 8 active pixels + 8 blanking clocks per line (hsync low at clocks 10..12),
// 4 active lines + 4 blanking lines per frame (vsync low on lines 5 and 6).
// Inputs change on the falling clock edge; outputs are read on falling edges.
module tb_vga_timing_rx;

  logic        clk;
  logic        rst_n;
  logic        hsync, vsync, de;
  logic [11:0] rgb_in;
  logic [10:0] px_x, px_y, line_len, frame_lines;
  logic        px_valid, frame_start, locked, err;
  logic [11:0] px_rgb;
`ifdef VGA_TIMING_RX_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
  logic [15:0] crc_golden;
`endif

  int  checks = 0;
  int  errors = 0;
  bit  rgb_zero = 1'b0;

  vga_timing_rx #(
    .H_ACTIVE    (8),
    .V_ACTIVE    (4),
    .SYNC_ACT    (1'b0),
    .LOCK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb_in      (rgb_in),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_valid    (px_valid),
    .px_rgb      (px_rgb),
    .frame_start (frame_start),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .locked      (locked),
    .err         (err)
`ifdef VGA_TIMING_RX_CRC_EN
    ,
    .frame_crc   (frame_crc),
    .crc_valid   (crc_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    logic [3:0] xv, yv;
    xv = x[3:0];
    yv = y[3:0];
    if (rgb_zero) return 12'h000;
    if (x == 5 && y == 3) return 12'hA5C;
    return {xv, yv, 4'h7};
  endfunction

`ifdef VGA_TIMING_RX_CRC_EN
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  // One clock of line y at position idx with nde active pixels.
  task automatic line_cycle(input int idx, input int nde, input logic vsl, input int y);
    @(negedge clk);
    de     = (idx < nde);
    hsync  = !((idx >= 10) && (idx <= 12));
    vsync  = vsl;
    rgb_in = (idx < nde) ? pix(idx, y) : 12'h000;
  endtask

  task automatic send_line(input int y, input int nde, input logic vsl);
    for (int idx = 0; idx < 16; idx++) line_cycle(idx, nde, vsl, y);
  endtask

  // Lines 0..4 of a frame; line bad_y gets 7 pixels instead of 8.
  task automatic frame_top(input int bad_y, input bit pix_chk);
    int nde;
    for (int y = 0; y < 5; y++) begin
      nde = (y == bad_y) ? 7 : ((y < 4) ? 8 : 0);
      for (int idx = 0; idx < 16; idx++) begin
        line_cycle(idx, nde, 1'b1, y);
        if (pix_chk && y == 0 && idx == 3) begin
          check("px0_x", px_x, 0);
          check("px0_y", px_y, 0);
          check("px0_valid", px_valid, 1);
        end
        if (pix_chk && y == 3 && idx == 8) begin
          check("px53_x", px_x, 5);
          check("px53_y", px_y, 3);
          check("px53_rgb", px_rgb, 12'hA5C);
          check("px53_valid", px_valid, 1);
        end
        if (pix_chk && y == 3 && idx == 11) check("px_blank_valid", px_valid, 0);
        if (y == bad_y && idx == 9) begin
          check("badln_lock_pre", locked, 1);
          check("badln_err_pre", err, 0);
        end
        if (y == bad_y && idx == 10) begin
          check("badln_lock_post", locked, 0);
          check("badln_err_post", err, 1);
          check("badln_len", line_len, 7);
        end
      end
    end
  endtask

  // Lines 5..7: vsync active edge at line 5 clock 0, visible at clock 3.
  task automatic frame_bottom(input logic lk_before, input logic lk_after, input logic exp_err);
    for (int idx = 0; idx < 16; idx++) begin
      line_cycle(idx, 0, 1'b0, 5);
      if (idx == 2) begin
        check("vs_lock_pre", locked, lk_before);
        check("vs_fs_pre", frame_start, 0);
      end
      if (idx == 3) begin
        check("vs_lock_post", locked, lk_after);
        check("vs_fs_pulse", frame_start, 1);
        check("vs_frame_lines", frame_lines, 4);
        check("vs_line_len", line_len, 8);
        check("vs_err", err, exp_err);
`ifdef VGA_TIMING_RX_CRC_EN
        if (rgb_zero) begin
          check("crc_valid_pulse", crc_valid, 1);
          check("crc_value", frame_crc, crc_golden);
        end
`endif
      end
      if (idx == 4) begin
        check("vs_fs_end", frame_start, 0);
`ifdef VGA_TIMING_RX_CRC_EN
        if (rgb_zero) check("crc_valid_end", crc_valid, 0);
`endif
      end
    end
    send_line(6, 0, 1'b0);
    send_line(7, 0, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    de     = 1'b0;
    rgb_in = 12'h000;
`ifdef VGA_TIMING_RX_CRC_EN
    crc_golden = 16'hFFFF;
    for (int i = 0; i < 32; i++) crc_golden = crc_ref(crc_golden, 16'h0000);
`endif
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_valid", px_valid, 0);
    check("rst_err", err, 0);
    check("rst_frame_lines", frame_lines, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // A: pre-vsync frame, SEARCH -> ACQ
    frame_top(-1, 1'b1);
    frame_bottom(1'b0, 1'b0, 1'b0);
    // B: first good frame (all-zero pixels)
    rgb_zero = 1'b1;
    frame_top(-1, 1'b0);
    frame_bottom(1'b0, 1'b0, 1'b0);
    rgb_zero = 1'b0;
    // C: second good frame -> LOCK
    frame_top(-1, 1'b0);
    frame_bottom(1'b0, 1'b1, 1'b0);
    // D: locked, pixel alignment
    frame_top(-1, 1'b1);
    frame_bottom(1'b1, 1'b1, 1'b0);
    // E: short line 2 drops lock and sets err
    frame_top(2, 1'b0);
    frame_bottom(1'b0, 1'b0, 1'b1);

    // F: reset pulse in the middle of line 2
    send_line(0, 8, 1'b1);
    send_line(1, 8, 1'b1);
    for (int idx = 0; idx < 5; idx++) line_cycle(idx, 8, 1'b1, 2);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_px_x", px_x, 0);
    check("mrst_px_y", px_y, 0);
    check("mrst_valid", px_valid, 0);
    check("mrst_rgb", px_rgb, 0);
    check("mrst_fs", frame_start, 0);
    check("mrst_line_len", line_len, 0);
    check("mrst_frame_lines", frame_lines, 0);
    check("mrst_locked", locked, 0);
    check("mrst_err", err, 0);
    line_cycle(5, 8, 1'b1, 2);
    rst_n = 1'b1;
    for (int idx = 6; idx < 16; idx++) begin
      line_cycle(idx, 8, 1'b1, 2);
      if (idx == 8) begin
        check("post_rst_x0", px_x, 0);
        check("post_rst_y0", px_y, 0);
        check("post_rst_valid", px_valid, 1);
      end
      if (idx == 9) check("post_rst_x1", px_x, 1);
    end
    for (int idx = 0; idx < 16; idx++) begin
      line_cycle(idx, 8, 1'b1, 3);
      if (idx == 3) begin
        check("post_rst_next_x", px_x, 0);
        check("post_rst_next_y", px_y, 1);
      end
    end

    // de high while hsync is active
    check("sync_err_clear", err, 0);
    @(negedge clk);
    hsync  = 1'b0;
    de     = 1'b1;
    rgb_in = 12'h123;
    @(negedge clk);
    hsync  = 1'b1;
    de     = 1'b0;
    rgb_in = 12'h000;
    @(negedge clk);
    check("sync_err_pre", err, 0);
    @(negedge clk);
    check("sync_err_set", err, 1);
    repeat (10) @(negedge clk);
    check("sync_err_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    check("sync_err_rst", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
